// File: rtl/mac_neuron.sv
// mac_neuron: signed 8.8 multiply-accumulate over N_INPUTS pairs plus bias,
// rounded toward -inf and saturated back to 8.8 for the sigmoid stage.
module mac_neuron #(
    parameter int N_INPUTS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] bias,
    input  logic        in_valid,
    input  logic [15:0] x_in,
    input  logic [15:0] w_in,
    output logic        in_ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] mac_out
);
    localparam int CW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int AW = 32 + $clog2(N_INPUTS) + 1;
    localparam int RW = AW - 8;
    localparam logic [CW-1:0] LAST = CW'(N_INPUTS - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, SAT} state_e;

    state_e               state_q;
    logic signed [AW-1:0] acc_q;
    logic [CW-1:0]        cnt_q;
    logic                 done_q;
    logic [15:0]          mac_q;
    logic signed [31:0]   prod;
    logic signed [RW-1:0] res;
    logic [15:0]          sat_d;
    logic                 unused_lsb;

    assign prod = $signed(x_in) * $signed(w_in);
    assign res = acc_q[AW-1:8];
    assign unused_lsb = ^acc_q[7:0];
    // fits in 8.8 only when every bit from 15 upward equals the sign bit
    assign sat_d = (&res[RW-1:15] || ~|res[RW-1:15]) ? res[15:0]
                 : (res[RW-1] ? 16'h8000 : 16'h7FFF);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            mac_q   <= 16'h0000;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    acc_q   <= AW'($signed(bias)) <<< 8;
                    cnt_q   <= '0;
                    state_q <= ACCUM;
                end
                ACCUM: if (in_valid) begin
                    acc_q   <= acc_q + AW'(prod);
                    cnt_q   <= cnt_q + CW'(1);
                    state_q <= (cnt_q == LAST) ? SAT : ACCUM;
                end
                SAT: begin
                    mac_q   <= sat_d;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready = (state_q == ACCUM);
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign mac_out  = mac_q;
endmodule

// File: tb/tb_mac_neuron.sv
// tb_mac_neuron: directed vectors against a 4-input and a 1-input neuron.
module tb_mac_neuron;
    logic        clk = 1'b0;
    logic        reset;
    logic        start4, in_valid4, in_ready4, busy4, done4;
    logic [15:0] bias4, x4, w4, mac4;
    logic        start1, in_valid1, in_ready1, busy1, done1;
    logic [15:0] bias1, x1, w1, mac1;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc_cnt = 0;
    int          last_done = 0;
    int          t_prev;
    logic [15:0] prev_mac = 16'h0000;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    mac_neuron #(.N_INPUTS(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .bias(bias4),
        .in_valid(in_valid4), .x_in(x4), .w_in(w4),
        .in_ready(in_ready4), .busy(busy4), .done(done4), .mac_out(mac4)
    );

    mac_neuron #(.N_INPUTS(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .bias(bias1),
        .in_valid(in_valid1), .x_in(x1), .w_in(w1),
        .in_ready(in_ready1), .busy(busy1), .done(done1), .mac_out(mac1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Starts at a negedge (possibly the done cycle of the previous run) and
    // returns at the negedge where done is visible.
    task automatic eval4(input string tag, input logic [15:0] b, input logic [63:0] xs,
                         input logic [63:0] ws, input logic [15:0] vpat, input int spulse,
                         input logic [15:0] exp, input int exp_lat);
        int k = 0;
        int c = 0;
        bias4  = b;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check({tag, ":busy"}, busy4, 1);
        check({tag, ":rdy0"}, in_ready4, 1);
        check({tag, ":done0"}, done4, 0);
        while (!done4 && c < 40) begin
            check({tag, ":hold"}, mac4, prev_mac);
            if (k < 4) check({tag, ":rdy"}, in_ready4, 1);
            in_valid4 = (k < 4) && ((c < 16) ? vpat[c] : 1'b1);
            x4 = (k < 4) ? xs[16*k +: 16] : 16'h0;
            w4 = (k < 4) ? ws[16*k +: 16] : 16'h0;
            start4 = (c == spulse);
            @(negedge clk);
            start4 = 1'b0;
            if (in_valid4) k++;
            c++;
        end
        in_valid4 = 1'b0;
        check({tag, ":done"}, done4, 1);
        check({tag, ":lat"}, c, exp_lat);
        check({tag, ":mac"}, mac4, exp);
        prev_mac  = exp;
        last_done = cyc_cnt;
    endtask

    task automatic eval1(input string tag, input logic [15:0] x, input logic [15:0] w,
                         input logic [15:0] exp);
        bias1  = 16'h0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check({tag, ":busy"}, busy1, 1);
        in_valid1 = 1'b1;
        x1 = x;
        w1 = w;
        @(negedge clk);
        in_valid1 = 1'b0;
        check({tag, ":sat"}, {in_ready1, done1}, 2'b00);
        @(negedge clk);
        check({tag, ":done"}, done1, 1);
        check({tag, ":mac"}, mac1, exp);
        @(negedge clk);
        check({tag, ":pulse"}, {done1, busy1}, 2'b00);
    endtask

    initial begin
        reset = 1'b1;
        {start4, in_valid4, bias4, x4, w4} = '0;
        {start1, in_valid1, bias1, x1, w1} = '0;
        repeat (3) @(negedge clk);
        check("rst4", {in_ready4, busy4, done4, mac4}, 19'h0);
        check("rst1", {in_ready1, busy1, done1, mac1}, 19'h0);
        reset = 1'b0;
        @(negedge clk);

        eval4("unit", 16'h0000, {4{16'h0100}}, {4{16'h0100}}, 16'hFFFF, -1, 16'h0400, 5);
        eval4("stall", 16'hFF00, {16'h0000, 16'h0000, 16'h0200, 16'h0200},
              {16'h7FFF, 16'h7FFF, 16'h0180, 16'h0180}, 16'h0059, -1, 16'h0500, 8);
        t_prev = last_done;
        eval4("satp", 16'h0000, {4{16'h7FFF}}, {4{16'h7FFF}}, 16'hFFFF, -1, 16'h7FFF, 5);
        check("b2b1", last_done - t_prev, 6);
        t_prev = last_done;
        eval4("satn", 16'h0000, {4{16'h8000}}, {4{16'h7FFF}}, 16'hFFFF, -1, 16'h8000, 5);
        check("b2b2", last_done - t_prev, 6);
        eval4("ign", 16'h0000, {4{16'h0100}}, {4{16'h0100}}, 16'hFFFF, 2, 16'h0400, 5);
        @(negedge clk);
        check("pulse", {done4, busy4}, 2'b00);

        bias4  = 16'h0000;
        start4 = 1'b1;
        @(negedge clk);
        start4    = 1'b0;
        in_valid4 = 1'b1;
        x4 = 16'h0100;
        w4 = 16'h4000;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        in_valid4 = 1'b0;
        check("midrst", {busy4, in_ready4, done4, mac4}, 19'h0);
        prev_mac = 16'h0000;
        @(negedge clk);
        eval4("fresh", 16'h0000, {4{16'h0100}}, {4{16'h0080}}, 16'hFFFF, -1, 16'h0200, 5);
        @(negedge clk);
        check("idle", {done4, busy4, mac4}, {2'b00, 16'h0200});

        eval1("trp", 16'h0001, 16'h0080, 16'h0000);
        eval1("trn", 16'hFFFF, 16'h0080, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mac_neuron.md
# mac_neuron

Fixed-point multiply-accumulate neuron that produces the pre-activation value for the sigmoid stage. It consumes a stream of N_INPUTS (input, weight) pairs in signed 8.8 format. It adds them to a bias and rounds the sum back to saturated 8.8. It then presents the result on `mac_out` with a one-cycle `done` pulse, which the activation stage samples as its `done`/`sig_in` pair.

## Interface
- N_INPUTS, 16, number of (x, w) pairs per neuron evaluation; minimum 1.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- start  in  1  begin an evaluation; honored only in IDLE.
- bias  in  16  signed 8.8 bias; sampled on the accepted start edge.
- in_valid  in  1  x_in/w_in hold a valid pair.
- x_in  in  16  signed 8.8 input activation.
- w_in  in  16  signed 8.8 weight.
- in_ready  out  1  block accepts a pair this cycle.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse; mac_out valid.
- mac_out  out  16  signed 8.8 saturated result; holds until the next done or reset.

## Operation
- States: IDLE, ACCUM, SAT.
- IDLE: in_ready=0. If start=1: acc <= sign_extend(bias) << 8, cnt <= 0, go to ACCUM. start is ignored in ACCUM and SAT.
- ACCUM: in_ready=1. A transfer occurs when in_valid && in_ready.
  - On each transfer: acc <= acc + x_in*w_in, cnt <= cnt+1.
  - On the transfer where cnt == N_INPUTS-1: go to SAT.
  - in_valid low stalls the block with no state change, for any number of cycles.
- SAT: register mac_out and assert done=1 for that edge, then go to IDLE.
- Arithmetic:
  - Product is a full 32-bit signed value in Q16.16.
  - acc is signed, 32+clog2(N_INPUTS)+1 bits wide, so it never overflows internally.
  - Result = acc >>> 8, an arithmetic shift that truncates toward negative infinity.
  - If the result > 32767, mac_out = 16'h7FFF. If it is < -32768, mac_out = 16'h8000. Otherwise mac_out = the low 16 bits.
- mac_out changes only on the SAT edge or on reset.
- Reset (any state, including mid-ACCUM): state=IDLE, acc=0, cnt=0, done=0, mac_out=16'h0000; the partial sum is discarded.
- Reset has priority over start and over transfers in the same cycle.

## Timing
- Reset values: in_ready=0, busy=0, done=0, mac_out=16'h0000.
- start sampled at edge E0: busy=1 and in_ready=1 from E0.
- Final pair accepted at edge Ek: in_ready=0 after Ek, SAT for one cycle.
- At edge Ek+1: done=1 and mac_out is valid; done drops at Ek+2; busy=0 after Ek+1.
- Minimum latency from start edge to done edge, with in_valid held high: N_INPUTS+1 cycles.
- start asserted during the done cycle is accepted: IDLE is entered at Ek+1, so start is sampled at Ek+2 at the earliest.
- Back-to-back evaluations: one done every N_INPUTS+2 cycles minimum.
- done never stays high for more than one cycle. The consumer must sample mac_out on done, or later while mac_out is holding.

## Test plan
- N_INPUTS=4, bias=0, four pairs x=0x0100, w=0x0100 with in_valid held high. Required: done exactly 5 cycles after the start edge, mac_out=0x0400, done high for exactly one cycle.
- N_INPUTS=4, bias=0xFF00 (-1.0), pairs (0x0200, 0x0180)×2 and (0x0000, 0x7FFF)×2, with in_valid toggling 1,0,0,1,1,0,1. Required: in_ready stays high through the stalls; mac_out=0x0500 (5.0); done occurs only after the 4th transfer.
- Saturation: four pairs 0x7FFF×0x7FFF gives mac_out=0x7FFF. Four pairs 0x8000×0x7FFF gives mac_out=0x8000.
- Truncation, N_INPUTS=1:
  - x=0x0001, w=0x0080 gives mac_out=0x0000.
  - x=0xFFFF, w=0x0080 gives mac_out=0xFFFF (truncation toward negative infinity).
- start pulsed during ACCUM is ignored and cnt is not reset. Then assert reset after 2 of 4 transfers. Required: the next cycle shows busy=0, in_ready=0, mac_out=0x0000. A fresh evaluation then returns a correct result, unaffected by the discarded partial sum.
- Back-to-back: start is re-asserted on the cycle done is high. Required: the second done arrives N_INPUTS+2 cycles after the first. mac_out holds the first result until the second done.
